// File: rtl/fm_phase_discriminator.sv
// fm_phase_discriminator
//   Turns per-sample CORDIC phase into instantiated frequency: the wrapped
//   phase difference between consecutive samples is integrated over DECIM
//   samples and dumped as the block mean.
//   Samples whose magnitude is below SQL_TH are squelched. They contribute
//   zero frequency and flag the block they fall in.
//
//   Optional feature (macro FM_DEEMPH_EN): a one-pole de-emphasis IIR
//   filter, y <= y + ((x - y) >>> DEEMPH_SHIFT), is applied to the
//   decimated mean. It adds one clock of latency. When the macro is
//   undefined, no filter registers are built.
//
//   Ports
//     clk          clock
//     rst_n        asynchronous active-low reset
//     i_valid      input sample strobe (any duty cycle)
//     i_phase      signed phase, +-32768 = +-pi
//     i_magnitude  unsigned CORDIC magnitude
//     i_clear      synchronous flush back to IDLE (wins over i_valid)
//     o_valid      one-cycle output strobe
//     o_data       signed frequency sample, LSB = pi/32768 rad/sample
//     o_squelch    block contained at least one squelched sample
//
//   state | meaning
//   IDLE  | waiting for the priming sample (no difference available yet)
//   RUN   | each sample yields a phase difference into the integrator
module fm_phase_discriminator #(
  parameter int          DECIM        = 8,
  parameter int          LOG2_DECIM   = 3,
  parameter logic [15:0] SQL_TH       = 16'd256,
  parameter int          DEEMPH_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic signed [15:0] i_phase,
  input  logic        [15:0] i_magnitude,
  input  logic               i_clear,
  output logic               o_valid,
  output logic signed [15:0] o_data,
  output logic               o_squelch
);

  localparam int AW = 16 + LOG2_DECIM;
  localparam int CW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic signed [15:0]     prev_phase;
  logic signed [AW-1:0]   acc;
  logic        [CW-1:0]   count;
  logic                   blk_sq;

  logic                   sample_sq;
  logic signed [15:0]     diff_raw;
  logic signed [15:0]     diff;
  logic signed [AW-1:0]   acc_sum;
  logic signed [15:0]     mean;
  logic                   last;

  // Modulo-2^16 subtraction already yields the principal value of the
  // phase step, so no explicit unwrap is needed.
  assign sample_sq = (i_magnitude < SQL_TH);
  assign diff_raw  = i_phase - prev_phase;
  assign diff      = sample_sq ? 16'sd0 : diff_raw;
  assign acc_sum   = acc + AW'(diff);
  // The mean of 16-bit values always fits in 16 bits, so truncation is safe.
  assign mean      = 16'(acc_sum >>> LOG2_DECIM);
  assign last      = (count == CW'(DECIM - 1));

`ifdef FM_DEEMPH_EN
  localparam int YW = 16 + DEEMPH_SHIFT;

  logic signed [15:0]   x_q;
  logic                 x_vld;
  logic                 x_sq;
  logic signed [YW-1:0] y;
  logic signed [YW:0]   y_err;
  logic signed [YW-1:0] y_next;

  assign y_err  = (YW+1)'(x_q) - (YW+1)'(y);
  assign y_next = y + YW'(y_err >>> DEEMPH_SHIFT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_phase <= '0;
      acc        <= '0;
      count      <= '0;
      blk_sq     <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_squelch  <= 1'b0;
`ifdef FM_DEEMPH_EN
      x_q        <= '0;
      x_vld      <= 1'b0;
      x_sq       <= 1'b0;
      y          <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
`ifdef FM_DEEMPH_EN
      x_vld   <= 1'b0;
      if (x_vld && !i_clear) begin
        y         <= y_next;
        o_data    <= o_data'(y_next);
        o_squelch <= x_sq;
        o_valid   <= 1'b1;
      end
`endif
      if (i_clear) begin
        state  <= IDLE;
        acc    <= '0;
        count  <= '0;
        blk_sq <= 1'b0;
`ifdef FM_DEEMPH_EN
        y      <= '0;
`endif
      end else if (i_valid) begin
        prev_phase <= i_phase;
        case (state)
          IDLE: state <= RUN;
          RUN: begin
            if (last) begin
              acc    <= '0;
              count  <= '0;
              blk_sq <= 1'b0;
`ifdef FM_DEEMPH_EN
              x_q    <= mean;
              x_sq   <= blk_sq | sample_sq;
              x_vld  <= 1'b1;
`else
              o_data    <= mean;
              o_squelch <= blk_sq | sample_sq;
              o_valid   <= 1'b1;
`endif
            end else begin
              acc    <= acc_sum;
              count  <= count + 1'b1;
              blk_sq <= blk_sq | sample_sq;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fm_phase_discriminator.md
Name: fm_phase_discriminator

Overview:
- Downstream neighbour of the CORDIC phase stage in the FM demodulator chain.
- Consumes per-sample phase (Q1.15, -π..π) plus magnitude, and computes the wrapped phase difference between consecutive samples (instantaneous frequency).
- Integrate-and-dump decimates by DECIM and applies a magnitude squelch.
- Output is a signed audio-rate sample stream with a valid strobe, feeding the audio DAC/FIFO stage.

Parameters:
- DECIM, 8, decimation ratio; power of two, 1..64.
- LOG2_DECIM, 3, log2(DECIM); must match DECIM.
- SQL_TH, 16'd256, squelch threshold; samples with magnitude below it contribute zero frequency.
- DEEMPH_SHIFT, 3, de-emphasis IIR coefficient shift (used only with FM_DEEMPH_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  input sample strobe; one sample per high cycle, any duty cycle
- i_phase  in  16  signed phase, full scale ±32768 = ±π
- i_magnitude  in  16  unsigned magnitude from CORDIC
- i_clear  in  1  synchronous flush; returns block to IDLE
- o_valid  out  1  one-cycle output strobe
- o_data  out  16  signed frequency sample (LSB = π/32768 rad/sample)
- o_squelch  out  1  high with o_valid if any sample in the dumped block was squelched

Behaviour:
- Reset (async): o_valid=0, o_data=0, o_squelch=0, prev_phase=0, acc=0, count=0, state=IDLE.
- FSM states:
  - IDLE: on i_valid, store prev_phase<=i_phase → RUN. No diff is produced from this first sample.
  - RUN: on each i_valid, compute diff = i_phase - prev_phase, truncated to 16 bits. Modulo-2^16 arithmetic gives the principal value in [-32768, 32767]; no explicit unwrap is performed. Then prev_phase<=i_phase.
- Squelch: if i_magnitude < SQL_TH, diff is replaced by 0 and the block squelch flag is set. prev_phase still updates.
- Accumulator:
  - acc is signed, 16+LOG2_DECIM bits; acc += diff; count increments 0..DECIM-1.
  - On the sample where count==DECIM-1: o_data <= (acc+diff) >>> LOG2_DECIM (arithmetic shift, truncation toward -inf), o_squelch <= block flag, o_valid=1 on the next cycle.
  - In the same cycle: acc<=0, count<=0, flag cleared.
  - No saturation is needed (mean of 16-bit values fits in 16 bits).
- Latency: o_valid rises exactly 1 clk after the DECIM-th accepted RUN sample. With DECIM=1, every RUN sample yields an output 1 clk later.
- o_valid is high for exactly 1 cycle. o_data and o_squelch hold their values between strobes.
- i_valid low: all state holds; gaps of any length are allowed.
- i_clear (priority over i_valid in the same cycle): state=IDLE, acc=0, count=0, flag=0. Outputs hold; o_valid forced 0. The next sample re-primes.
- Reset mid-block: partial accumulation is discarded and no output is emitted.

Optional Feature:
- Macro: FM_DEEMPH_EN.
- Defined: the decimated mean x feeds a one-pole de-emphasis filter y <= y + ((x - y) >>> DEEMPH_SHIFT).
  - y is 16+DEEMPH_SHIFT bits internally; o_data = y truncated to 16 bits.
  - Adds 1 clk latency, so o_valid rises 2 clk after the DECIM-th sample.
  - y resets to 0 on rst_n and is cleared by i_clear.
- Undefined: o_data is the raw decimated mean with 1-clk latency; no filter registers exist.

Test Plan:
- DECIM=8, i_magnitude=1000, i_phase ramps +1024 per valid from 0 → first o_valid 1 clk after the 9th input, o_data=1024, o_squelch=0; then an output every 8 inputs, o_data=1024.
- DECIM=1, phase 32000 then -32000 → o_data=+1536 (wrap handled); then phase -32000 → 32000 gives o_data=-1536.
- DECIM=8, ramp -512 per valid with 3-cycle i_valid gaps → o_data=-512 each output; output count = (N-1)/8.
- DECIM=8, ramp +1024, i_magnitude=100 for samples 2..5 of a block, 1000 otherwise → o_data=(4·1024)>>>3=512, o_squelch=1; next block o_squelch=0.
- i_clear asserted together with i_valid after 5 RUN samples → no output; the next output needs 1 priming sample + 8 samples. Same check with rst_n pulsed mid-block: o_valid=0, o_data=0 immediately (async).
- FM_DEEMPH_EN, DEEMPH_SHIFT=3, constant mean 1024 → o_data sequence 128, 240, 338…, converging to 1024 (within 8 LSB); o_valid 2 clk after the block-completing sample.
